load_pipe_ou: RTL and testbench
===============================

LOAD_PIPE_OU -- requirements
Module: load_pipe_ou

Interface
REQ-001 Parameter LOAD_FN3, default LS_H_fn3, 3-bit LSQ access-size/sign code driven on fn3.
REQ-002 Parameter ADDR_OFFSET, default 0, XLEN-bit constant added to data_in1 to form addr.
REQ-003 Parameter MAX_OUTSTANDING, default 4, range 1..16, cap on issued-but-incomplete loads.
REQ-004 Parameter RESULT_DEPTH, default 4, power of 2, range 2..16, result FIFO entries.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 data_in1 / data_in2  in  XLEN  operands; data_in1 is base address, data_in2 unused.
REQ-008 data_valid_in1 / data_valid_in2  in  1  operand valid.
REQ-009 data_in_ack1 / data_in_ack2  out  1  operand consumed this cycle.
REQ-010 uses_data_in1 / uses_data_in2  out  1  constant 1 / 0.
REQ-011 data_out  out  XLEN  FIFO head (or bypassed load_data, see REQ-030).
REQ-012 data_valid_out  out  1  data_out valid.
REQ-013 data_out_ack  in  1  consumer accepts data_out; transfer when data_valid_out && data_out_ack.
REQ-014 addr, data  out  XLEN  LSQ address; store data (constant 0).
REQ-015 fn3  out  3  constant LOAD_FN3; load / store  out  1  constant 1 / 0.
REQ-016 new_request  out  1  LSQ request strobe; lsq_full  in  1  LSQ cannot accept.
REQ-017 load_data  in  XLEN, load_complete  in  1  in-order LSQ load return.

Function
REQ-018 addr SHALL equal data_in1 + ADDR_OFFSET modulo 2^XLEN, no overflow indication.
REQ-019 outstanding counter (0..MAX_OUTSTANDING) and fifo_count (0..RESULT_DEPTH); in_flight = outstanding + fifo_count.
REQ-020 issue = !rst && data_valid_in1 && !lsq_full && outstanding < MAX_OUTSTANDING && in_flight < RESULT_DEPTH.
REQ-021 new_request and data_in_ack1 SHALL both equal issue, combinationally, same cycle; data_in_ack2 SHALL be 0.
REQ-022 On issue, outstanding SHALL increment next cycle; on accepted completion it SHALL decrement; both same cycle leaves it unchanged.
REQ-023 load_complete with outstanding == 0 SHALL be ignored: no push, no counter change.
REQ-024 Accepted completion SHALL push load_data into FIFO (unless bypassed, REQ-030); visible on data_out next cycle if FIFO was empty.
REQ-025 data_valid_out SHALL be (fifo_count != 0); data_out SHALL be head entry; data_out SHALL hold stable while valid and not acked.
REQ-026 Pop on data_valid_out && data_out_ack; push and pop same cycle leaves fifo_count unchanged, including at full.
REQ-027 Credit rule (REQ-020) SHALL guarantee no FIFO overflow; write/read pointers wrap modulo RESULT_DEPTH.
REQ-028 Results SHALL leave in issue order; no reordering, no drop.

Reset
REQ-029 While rst high: outstanding=0, fifo_count=0, pointers=0, data_valid_out=0, new_request=0, data_in_ack1=0; FIFO contents need not clear. Reset mid-operation discards in-flight loads; late completions fall under REQ-023.

Configuration
REQ-030 Macro RCA_LOAD_PIPE_BYPASS_EN defined: when FIFO empty and completion accepted, data_out=load_data and data_valid_out=1 same cycle; if data_out_ack also high, entry not pushed and outstanding decrements (zero-latency). Undefined: no bypass, minimum completion-to-valid latency 1 cycle.

Verification
REQ-031 Defaults, data_in1=0x1000 valid, lsq_full=0 -> new_request=1, addr=0x1000, fn3=LS_H_fn3, ack1=1 same cycle; completion load_data=0xBEEF -> data_valid_out=1 next cycle, data_out=0xBEEF.
REQ-032 ADDR_OFFSET=8, data_in1=0xFFFFFFFC -> addr=0x00000004 (XLEN=32).
REQ-033 data_out_ack=0, 4 back-to-back issues and completions -> fifth issue blocked (ack1=0) until one pop; pop order equals issue order.
REQ-034 MAX_OUTSTANDING=2, no completions, 3 valid cycles -> exactly 2 new_request pulses; lsq_full=1 -> no issue.
REQ-035 rst asserted with 2 outstanding, then load_complete pulses -> data_valid_out stays 0, counters stay 0.
REQ-036 With RCA_LOAD_PIPE_BYPASS_EN, FIFO empty, load_complete + data_out_ack same cycle, load_data=0x55 -> data_out=0x55, data_valid_out=1 that cycle; fifo_count stays 0.

Source files
------------

// File: rtl/load_pipe_ou.sv
// Load pipe: issues one LSQ load per operand and returns results in issue order through a small FIFO.
// Optional RCA_LOAD_PIPE_BYPASS_EN forwards a completion straight to data_out when the FIFO is empty.
module load_pipe_ou #(
    parameter int               XLEN            = 32,
    parameter logic [2:0]       LOAD_FN3        = 3'b001,  // LS_H_fn3
    parameter logic [XLEN-1:0]  ADDR_OFFSET     = '0,
    parameter int               MAX_OUTSTANDING = 4,
    parameter int               RESULT_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] data_in1,
    input  logic [XLEN-1:0] data_in2,
    input  logic            data_valid_in1,
    input  logic            data_valid_in2,
    output logic            data_in_ack1,
    output logic            data_in_ack2,
    output logic            uses_data_in1,
    output logic            uses_data_in2,
    output logic [XLEN-1:0] data_out,
    output logic            data_valid_out,
    input  logic            data_out_ack,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] data,
    output logic [2:0]      fn3,
    output logic            load,
    output logic            store,
    output logic            new_request,
    input  logic            lsq_full,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_complete
);

    localparam int PW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
    localparam int CW = 5;

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_flight;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] mem [RESULT_DEPTH];

    logic issue;
    logic accept;
    logic bypass;
    logic push;
    logic pop;
    logic fifo_empty;
    logic unused;

    assign unused = ^{data_in2, data_valid_in2};

    assign uses_data_in1 = 1'b1;
    assign uses_data_in2 = 1'b0;
    assign data_in_ack2  = 1'b0;
    assign data          = '0;
    assign fn3           = LOAD_FN3;
    assign load          = 1'b1;
    assign store         = 1'b0;
    assign addr          = data_in1 + ADDR_OFFSET;

    // Credits cover both the LSQ side and FIFO space, so a completion always has a slot.
    assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
    assign issue     = !rst && data_valid_in1 && !lsq_full
                       && (outstanding < CW'(MAX_OUTSTANDING))
                       && (in_flight < (CW+1)'(RESULT_DEPTH));

    assign new_request  = issue;
    assign data_in_ack1 = issue;

    assign accept     = !rst && load_complete && (outstanding != '0);
    assign fifo_empty = (fifo_count == '0);

`ifdef RCA_LOAD_PIPE_BYPASS_EN
    assign bypass = accept && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign data_valid_out = !rst && (!fifo_empty || bypass);
    assign data_out       = bypass ? load_data : mem[rd_ptr];

    assign pop  = data_valid_out && data_out_ack && !fifo_empty;
    // A bypassed result that is taken immediately never touches the FIFO.
    assign push = accept && !(bypass && data_out_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue, accept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= load_data;
        end
    end

endmodule

// File: tb/tb_load_pipe_ou.sv
// Randomized scoreboard bench for load_pipe_ou with a transaction-level model of credits and ordering.
// A second instance covers a non-zero address offset and a reduced outstanding limit.
module tb_load_pipe_ou;

    localparam int          MAXO     = 4;
    localparam int          DEPTH    = 4;
    localparam logic [2:0]  LS_H_FN3 = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in1 = '0, data_in2 = '0;
    logic        data_valid_in1 = 1'b0, data_valid_in2 = 1'b0;
    logic        data_in_ack1, data_in_ack2, uses_data_in1, uses_data_in2;
    logic [31:0] data_out;
    logic        data_valid_out;
    logic        data_out_ack = 1'b0;
    logic [31:0] addr, data;
    logic [2:0]  fn3;
    logic        load, store, new_request;
    logic        lsq_full = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_complete = 1'b0;

    logic        b_rst = 1'b1;
    logic [31:0] b_in1 = '0;
    logic        b_valid = 1'b0, b_full = 1'b0;
    logic        b_ack1, b_ack2, b_uses1, b_uses2, b_valid_out, b_load, b_store, b_new;
    logic [31:0] b_out, b_addr, b_data;
    logic [2:0]  b_fn3;

    int n_checks = 0;
    int n_fail   = 0;
    int ref_fifo = 0;
    logic [31:0] lsq_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    load_pipe_ou dut (
        .clk(clk), .rst(rst),
        .data_in1(data_in1), .data_in2(data_in2),
        .data_valid_in1(data_valid_in1), .data_valid_in2(data_valid_in2),
        .data_in_ack1(data_in_ack1), .data_in_ack2(data_in_ack2),
        .uses_data_in1(uses_data_in1), .uses_data_in2(uses_data_in2),
        .data_out(data_out), .data_valid_out(data_valid_out), .data_out_ack(data_out_ack),
        .addr(addr), .data(data), .fn3(fn3), .load(load), .store(store),
        .new_request(new_request), .lsq_full(lsq_full),
        .load_data(load_data), .load_complete(load_complete)
    );

    load_pipe_ou #(.ADDR_OFFSET(32'd8), .MAX_OUTSTANDING(2)) dut2 (
        .clk(clk), .rst(b_rst),
        .data_in1(b_in1), .data_in2(32'h0),
        .data_valid_in1(b_valid), .data_valid_in2(1'b0),
        .data_in_ack1(b_ack1), .data_in_ack2(b_ack2),
        .uses_data_in1(b_uses1), .uses_data_in2(b_uses2),
        .data_out(b_out), .data_valid_out(b_valid_out), .data_out_ack(1'b0),
        .addr(b_addr), .data(b_data), .fn3(b_fn3), .load(b_load), .store(b_store),
        .new_request(b_new), .lsq_full(b_full),
        .load_data(32'h0), .load_complete(1'b0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides from transaction counts what the DUT must do.
    task automatic cycle(input logic r, input logic v, input logic [31:0] a, input logic full,
                         input logic comp, input logic [31:0] idata, input logic ack);
        logic exp_issue, exp_valid, acc, popx;
        @(posedge clk); #1;
        rst            = r;
        data_valid_in1 = v;
        data_in1       = a;
        lsq_full       = full;
        load_complete  = comp;
        load_data      = (lsq_q.size() > 0) ? lsq_q[0] : $urandom;
        data_out_ack   = ack;
        data_in2       = $urandom;
        data_valid_in2 = 1'($urandom);
        @(negedge clk);
        if (r) begin
            exp_issue = 1'b0;
            exp_valid = 1'b0;
            acc       = 1'b0;
        end else begin
            acc       = comp && (lsq_q.size() > 0);
            exp_issue = v && !full && (lsq_q.size() < MAXO) && (lsq_q.size() + ref_fifo < DEPTH);
            exp_valid = (ref_fifo != 0);
`ifdef RCA_LOAD_PIPE_BYPASS_EN
            exp_valid = exp_valid || acc;
`endif
        end
        chk("new_request", 32'(new_request), 32'(exp_issue));
        chk("data_in_ack1", 32'(data_in_ack1), 32'(exp_issue));
        chk("data_in_ack2", 32'(data_in_ack2), 32'd0);
        chk("data_valid_out", 32'(data_valid_out), 32'(exp_valid));
        chk("addr", addr, a);
        if (r) begin
            lsq_q.delete();
            exp_q.delete();
            ref_fifo = 0;
        end else begin
            popx = exp_valid && ack;
            if (acc) void'(lsq_q.pop_front());
            if (exp_issue) begin
                lsq_q.push_back(idata);
                exp_q.push_back(idata);
            end
            ref_fifo = ref_fifo + int'(acc) - int'(popx);
        end
    endtask

    // Monitor: every accepted output must be the oldest outstanding expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && data_valid_out && data_out_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", data_out);
                end else begin
                    chk("data_out_order", data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int cnt;
        // Reset: no issue even with a valid operand.
        cycle(1, 1, 32'h10, 0, 0, 32'h0, 0);
        cycle(1, 1, 32'h20, 0, 1, 32'h0, 1);
        chk("uses_data_in1", 32'(uses_data_in1), 32'd1);
        chk("uses_data_in2", 32'(uses_data_in2), 32'd0);
        chk("load_store", {30'd0, load, store}, 32'd2);
        chk("store_data", data, 32'd0);
        chk("fn3", 32'(fn3), 32'(LS_H_FN3));

        // Basic issue and completion.
        cycle(0, 1, 32'h1000, 0, 0, 32'hBEEF, 0);
        chk("first_issue", 32'(new_request), 32'd1);
        chk("first_addr", addr, 32'h1000);
        chk("first_ack1", 32'(data_in_ack1), 32'd1);
        cycle(0, 0, 32'h0, 0, 1, 32'h0, 0);
        cycle(0, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("beef_valid", 32'(data_valid_out), 32'd1);
        chk("beef_data", data_out, 32'hBEEF);
        cycle(0, 0, 32'h0, 0, 0, 32'h0, 1);
        cycle(0, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("empty_after_pop", 32'(data_valid_out), 32'd0);

        // Fill the FIFO with no consumer; the fifth operand must wait for a pop.
        for (int i = 0; i < 4; i++)
            cycle(0, 1, 32'h2000 + 32'(i * 4), 0, (i > 0), 32'hA000 + 32'(i), 0);
        cycle(0, 0, 32'h0, 0, 1, 32'h0, 0);
        cycle(0, 1, 32'h3000, 0, 0, 32'hB000, 0);
        chk("fifth_blocked", 32'(data_in_ack1), 32'd0);
        cycle(0, 1, 32'h3000, 0, 0, 32'hB000, 1);
        chk("blocked_during_pop", 32'(data_in_ack1), 32'd0);
        cycle(0, 1, 32'h3000, 0, 0, 32'hB000, 0);
        chk("fifth_after_pop", 32'(data_in_ack1), 32'd1);
        repeat (8) cycle(0, 0, 32'h0, 0, 1, 32'h0, 1);

`ifdef RCA_LOAD_PIPE_BYPASS_EN
        cycle(0, 1, 32'h4000, 0, 0, 32'h55, 0);
        cycle(0, 0, 32'h0, 0, 1, 32'h0, 1);
        chk("bypass_valid", 32'(data_valid_out), 32'd1);
        chk("bypass_data", data_out, 32'h55);
        cycle(0, 0, 32'h0, 0, 0, 32'h0, 0);
        chk("bypass_no_push", 32'(data_valid_out), 32'd0);
`endif

        // Reset with loads in flight; late completions are ignored.
        cycle(0, 1, 32'h5000, 0, 0, 32'hC001, 0);
        cycle(0, 1, 32'h5004, 0, 0, 32'hC002, 0);
        cycle(1, 0, 32'h0, 0, 1, 32'h0, 0);
        cycle(0, 0, 32'h0, 0, 1, 32'h0, 0);
        cycle(0, 0, 32'h0, 0, 1, 32'h0, 1);
        chk("late_complete_ignored", 32'(data_valid_out), 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 249) == 0), ($urandom_range(0, 9) < 7), $urandom,
                  ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 5), $urandom,
                  ($urandom_range(0, 9) < 6));
        repeat (30) cycle(0, 0, 32'h0, 0, 1, 32'h0, 1);
        chk("all_results_delivered", 32'(exp_q.size()), 32'd0);

        // Offset wrap and outstanding limit on the second instance.
        @(posedge clk); #1;
        b_rst = 1'b0; b_valid = 1'b1; b_in1 = 32'hFFFF_FFFC; b_full = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (b_new) cnt++;
            chk("offset_addr", b_addr, 32'h4);
            @(posedge clk); #1;
        end
        chk("max_out_pulses", 32'(cnt), 32'd2);
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0; b_full = 1'b1;
        @(negedge clk);
        chk("lsq_full_blocks", 32'(b_new), 32'd0);
        @(posedge clk); #1;
        b_full = 1'b0;
        @(negedge clk);
        chk("issue_after_full", 32'(b_new), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
